// File: rtl/inta_sequencer_8259.sv
// rtl/inta_sequencer_8259.sv - 8259 two-pulse INTA sequencer with vector capture; optional INT_SYNC_EN input synchronizer
module inta_sequencer_8259 #(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_enable,
    input  logic       int_request,
    input  logic [7:0] data_bus_in,
    output logic       inta_n,
    output logic [7:0] vector_out,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy,
    output logic [7:0] ack_count
);

    localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INTA1   = 3'd1,
        GAP     = 3'd2,
        INTA2   = 3'd3,
        PRESENT = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       load_vector;
    logic       transfer;
    logic       req_sampled;

`ifdef INT_SYNC_EN
    logic [1:0] req_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_sync <= 2'b00;
        end else begin
            req_sync <= {req_sync[0], int_request};
        end
    end

    assign req_sampled = req_sync[1];
`else
    assign req_sampled = int_request;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            vector_out <= 8'h00;
            ack_count  <= 8'h00;
        end else begin
            state <= state_next;
            count <= count_next;
            if (load_vector) begin
                vector_out <= data_bus_in;
            end
            if (transfer) begin
                ack_count <= ack_count + 8'd1;
            end
        end
    end

    // The counter holds "clocks remaining minus one" and is reloaded whenever a timed state is entered.
    always_comb begin
        state_next  = state;
        count_next  = count;
        load_vector = 1'b0;
        transfer    = 1'b0;
        case (state)
            IDLE: begin
                count_next = 4'd0;
                if (req_sampled && interrupt_enable) begin
                    state_next = INTA1;
                    count_next = LOW_LOAD;
                end
            end
            INTA1: begin
                if (count == 4'd0) begin
                    state_next = GAP;
                    count_next = GAP_LOAD;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            GAP: begin
                if (count == 4'd0) begin
                    state_next = INTA2;
                    count_next = LOW_LOAD;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            INTA2: begin
                if (count == 4'd0) begin
                    state_next  = PRESENT;
                    count_next  = 4'd0;
                    load_vector = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            PRESENT: begin
                count_next = 4'd0;
                if (vector_ready) begin
                    state_next = IDLE;
                    transfer   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset releases inta_n without a clock.
    assign inta_n       = !((state == INTA1) || (state == INTA2));
    assign vector_valid = (state == PRESENT);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_inta_sequencer_8259.sv
// tb/tb_inta_sequencer_8259.sv - directed self-checking bench for inta_sequencer_8259
module tb_inta_sequencer_8259;

`ifdef INT_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       interrupt_enable;
    logic       int_request;
    logic [7:0] data_bus_in;
    logic       inta_n;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic       vector_ready;
    logic       busy;
    logic [7:0] ack_count;

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [7:0] exp_ack;

    inta_sequencer_8259 #(.INTA_LOW_CYCLES(2), .INTA_GAP_CYCLES(2)) dut (
        .clock(clock),
        .reset(reset),
        .interrupt_enable(interrupt_enable),
        .int_request(int_request),
        .data_bus_in(data_bus_in),
        .inta_n(inta_n),
        .vector_out(vector_out),
        .vector_valid(vector_valid),
        .vector_ready(vector_ready),
        .busy(busy),
        .ack_count(ack_count)
    );

    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; interrupt_enable = 1'b0; int_request = 1'b0;
        data_bus_in = 8'h00; vector_ready = 1'b0;
        #2;
        checks_total++;
        if ({inta_n, vector_valid, busy, vector_out, ack_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00})
            $display("FAIL reset_state: got inta_n=%b valid=%b busy=%b vec=%h ack=%h expected 1 0 0 00 00",
                     inta_n, vector_valid, busy, vector_out, ack_count);
        else checks_passed++;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        next_cycle();
        checks_total++;
        if ({inta_n, busy, ack_count} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_release: got inta_n=%b busy=%b ack=%h expected 1 0 00", inta_n, busy, ack_count);
        else checks_passed++;
        exp_ack = 8'h00;
    endtask

    task automatic test_basic();
        logic       e_inta, e_busy, e_valid;
        logic [7:0] e_ack;
        vector_ready = 1'b1; data_bus_in = 8'h4A; interrupt_enable = 1'b1; int_request = 1'b1;
        for (int c = 0; c <= 9 + L; c++) begin
            @(negedge clock);
            e_inta  = !((c >= 1 + L && c <= 2 + L) || (c >= 5 + L && c <= 6 + L));
            e_busy  = (c >= 1 + L && c <= 7 + L);
            e_valid = (c == 7 + L);
            e_ack   = (c >= 8 + L) ? exp_ack + 8'd1 : exp_ack;
            checks_total++;
            if ({inta_n, busy, vector_valid, ack_count} !== {e_inta, e_busy, e_valid, e_ack})
                $display("FAIL basic_cycle%0d: got inta_n=%b busy=%b valid=%b ack=%h expected %b %b %b %h",
                         c, inta_n, busy, vector_valid, ack_count, e_inta, e_busy, e_valid, e_ack);
            else checks_passed++;
            if (c == 7 + L) begin
                checks_total++;
                if (vector_out !== 8'h4A) $display("FAIL basic_vector: got %h expected 4a", vector_out);
                else checks_passed++;
            end
            next_cycle();
            if (c == 0) int_request = 1'b0;
        end
        exp_ack = exp_ack + 8'd1;
    endtask

    task automatic test_disabled();
        interrupt_enable = 1'b0; int_request = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks_total++;
            if ({inta_n, busy} !== 2'b10)
                $display("FAIL disabled_cycle%0d: got inta_n=%b busy=%b expected 1 0", c, inta_n, busy);
            else checks_passed++;
            next_cycle();
        end
        int_request = 1'b0;
        repeat (3) next_cycle();
        interrupt_enable = 1'b1;
    endtask

    task automatic test_hold();
        logic e_busy, e_valid;
        vector_ready = 1'b0; data_bus_in = 8'h5C; interrupt_enable = 1'b1; int_request = 1'b1;
        for (int c = 0; c <= 18 + L; c++) begin
            if (c == 1) int_request = 1'b0;
            if (c == 2 + L) interrupt_enable = 1'b0;
            if (c >= 7 + L) data_bus_in = 8'(c * 37);
            if (c == 17 + L) vector_ready = 1'b1;
            @(negedge clock);
            e_busy  = (c >= 1 + L && c <= 17 + L);
            e_valid = (c >= 7 + L && c <= 17 + L);
            checks_total++;
            if ({busy, vector_valid} !== {e_busy, e_valid})
                $display("FAIL hold_cycle%0d: got busy=%b valid=%b expected %b %b", c, busy, vector_valid, e_busy, e_valid);
            else checks_passed++;
            if (e_valid) begin
                checks_total++;
                if (vector_out !== 8'h5C) $display("FAIL hold_vector_cycle%0d: got %h expected 5c", c, vector_out);
                else checks_passed++;
            end
            if (c == 18 + L) begin
                checks_total++;
                if (ack_count !== exp_ack + 8'd1)
                    $display("FAIL hold_ack: got %h expected %h", ack_count, exp_ack + 8'd1);
                else checks_passed++;
            end
            next_cycle();
        end
        exp_ack = exp_ack + 8'd1;
        interrupt_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        vector_ready = 1'b1; data_bus_in = 8'h77; interrupt_enable = 1'b1; int_request = 1'b1;
        next_cycle();
        int_request = 1'b0;
        repeat (4 + L) next_cycle();
        @(negedge clock);
        checks_total++;
        if ({inta_n, busy} !== 2'b01) $display("FAIL mid_inta2: got inta_n=%b busy=%b expected 0 1", inta_n, busy);
        else checks_passed++;
        #2 reset = 1'b1;
        #1;
        checks_total++;
        if ({inta_n, vector_valid, busy, vector_out, ack_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00})
            $display("FAIL mid_reset_async: got inta_n=%b valid=%b busy=%b vec=%h ack=%h expected 1 0 0 00 00",
                     inta_n, vector_valid, busy, vector_out, ack_count);
        else checks_passed++;
        next_cycle();
        reset = 1'b0;
        exp_ack = 8'h00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks_total++;
            if ({inta_n, busy} !== 2'b10)
                $display("FAIL mid_after_release%0d: got inta_n=%b busy=%b expected 1 0", c, inta_n, busy);
            else checks_passed++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int         ph;
        logic       e_inta, e_busy;
        logic [7:0] e_ack;
        vector_ready = 1'b1; data_bus_in = 8'hA5; interrupt_enable = 1'b1; int_request = 1'b1;
        for (int c = 0; c <= L + 2048; c++) begin
            @(negedge clock);
            ph     = (c >= 1 + L) ? (c - 1 - L) % 8 : -1;
            e_busy = (ph >= 0 && ph != 7);
            e_inta = !(ph == 0 || ph == 1 || ph == 4 || ph == 5);
            checks_total++;
            if ({inta_n, busy} !== {e_inta, e_busy})
                $display("FAIL b2b_cycle%0d: got inta_n=%b busy=%b expected %b %b", c, inta_n, busy, e_inta, e_busy);
            else checks_passed++;
            if (ph == 7) begin
                e_ack = 8'((c - 1 - L) / 8 + 1);
                checks_total++;
                if (ack_count !== e_ack) $display("FAIL b2b_ack_cycle%0d: got %h expected %h", c, ack_count, e_ack);
                else checks_passed++;
            end
            next_cycle();
        end
        checks_total++;
        if (vector_out !== 8'hA5) $display("FAIL b2b_vector: got %h expected a5", vector_out);
        else checks_passed++;
        int_request = 1'b0;
        repeat (12) next_cycle();
        checks_total++;
        if ({busy, ack_count} !== {1'b0, 8'h01})
            $display("FAIL b2b_tail: got busy=%b ack=%h expected 0 01", busy, ack_count);
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_disabled();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/inta_sequencer_8259.md
INTA_SEQUENCER_8259 -- requirements
Module: inta_sequencer_8259

Interface
REQ-001 SHALL have parameter INTA_LOW_CYCLES, default 2: INTA pulse low width in clocks; legal range 1..15.
REQ-002 SHALL have parameter INTA_GAP_CYCLES, default 2: inta_n high time between the two pulses, in clocks; legal range 1..15.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port interrupt_enable, input, 1: CPU interrupt flag; 1 permits a new acknowledge sequence.
REQ-006 SHALL have port int_request, input, 1: INT line from the PIC, active-high.
REQ-007 SHALL have port data_bus_in, input, 8: PIC data bus, carrying the vector during the second INTA pulse.
REQ-008 SHALL have port inta_n, output, 1: acknowledge strobe to the PIC, active-low.
REQ-009 SHALL have port vector_out, output, 8: captured interrupt vector.
REQ-010 SHALL have port vector_valid, output, 1: vector_out is valid.
REQ-011 SHALL have port vector_ready, input, 1: the consumer accepts the vector.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port ack_count, output, 8: count of completed vector transfers.

Function
REQ-014 SHALL implement FSM states IDLE, INTA1, GAP, INTA2 and PRESENT.
REQ-015 SHALL leave IDLE for INTA1 on the edge where the sampled request is 1 and interrupt_enable is 1; otherwise SHALL stay in IDLE.
REQ-016 SHALL drive inta_n=0 for exactly INTA_LOW_CYCLES clocks in INTA1, then move to GAP.
REQ-017 SHALL drive inta_n=1 for exactly INTA_GAP_CYCLES clocks in GAP, then move to INTA2.
REQ-018 SHALL drive inta_n=0 for exactly INTA_LOW_CYCLES clocks in INTA2.
REQ-019 SHALL load data_bus_in into vector_out on the last INTA2 clock, then move to PRESENT.
REQ-020 SHALL assert vector_valid only in PRESENT, holding vector_out stable until vector_ready=1 is sampled.
REQ-021 On that transfer edge, SHALL return to IDLE and increment ack_count modulo 256 (255 wraps to 0).
REQ-022 SHALL spend at least one clock in IDLE after every transfer, so a request still held high starts the next sequence one clock later.
REQ-023 SHALL complete any started sequence even if int_request or interrupt_enable falls mid-sequence, capturing whatever data_bus_in carries.
REQ-024 SHALL ignore vector_ready outside PRESENT.
REQ-025 SHALL use a single 4-bit down-counter shared by INTA1, GAP and INTA2, reloaded on every state entry.
REQ-026 SHALL make the minimum latency from the sampled request to vector_valid 2*INTA_LOW_CYCLES+INTA_GAP_CYCLES+1 clocks.

Reset
REQ-027 On reset assertion SHALL immediately, without waiting for a clock edge, force state=IDLE, inta_n=1, vector_out=8'h00, vector_valid=0, busy=0, ack_count=8'h00 and clear the counter and any synchronizer flops.
REQ-028 Reset asserted mid-pulse SHALL release inta_n high immediately; no partial sequence resumes after reset.

Configuration
REQ-029 SHALL use the macro INT_SYNC_EN to select how int_request is sampled.
REQ-030 With INT_SYNC_EN defined, SHALL pass int_request through a two-flop synchronizer (reset to 0) before the FSM, adding 2 clocks of latency.
REQ-031 Without INT_SYNC_EN, SHALL have the FSM sample int_request directly.

Verification
REQ-032 Defaults, no INT_SYNC_EN; int_request=1 and interrupt_enable=1 at cycle 0; data_bus_in=8'h4A; vector_ready=1 -> inta_n low in cycles 1-2 and 5-6, vector_out=8'h4A with vector_valid=1 in cycle 7, ack_count=1.
REQ-033 interrupt_enable=0 with int_request=1 for 20 cycles -> inta_n stays 1, busy stays 0.
REQ-034 vector_ready=0 for 10 cycles in PRESENT with data_bus_in changing -> vector_out and vector_valid stay constant; the first cycle with ready=1 transfers and returns to IDLE.
REQ-035 Reset asserted during INTA2 -> inta_n=1 and all outputs at reset values asynchronously; after release with int_request=0, FSM stays IDLE.
REQ-036 256 back-to-back acknowledges with int_request held 1 -> ack_count wraps to 8'h00; exactly one IDLE cycle between sequences.
REQ-037 INT_SYNC_EN defined, scenario of REQ-032 -> every event shifted 2 clocks later.
